// File: rtl/sam_core_p.sv
// sam_core_p: parametrised single-accumulator CPU driving a multiplexed ALE/En/Rw memory bus.
// Two-word instructions; control, datapath and bus interface share one state machine.
`timescale 1ns/1ps
module sam_core_p #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic [1:0]        regSelect,
  output logic [DATA_W-1:0] dispReg,
  output logic [ADDR_W-1:0] Address_Bus,
  inout  wire  [DATA_W-1:0] Data_Bus,
  output logic              ALE,
  output logic              En,
  output logic              Rw
);
  typedef enum logic [2:0] {FETCH_A, FETCH_D, OPND_A, OPND_D, EXEC_A, EXEC_D, HALT} state_t;
  state_t state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] acc, ir, opnd, res;
  logic [DATA_W:0] sum, dif;
  logic [3:0] opc;
  logic z, c, taken, mem_op, is_sta, in_exec;
  assign opc     = ir[3:0];
  assign mem_op  = opc >= 4'd2 && opc <= 4'd7;
  assign is_sta  = opc == 4'd3;
  assign taken   = opc == 4'd8 || (opc == 4'd9 && z) || (opc == 4'hA && c);
  assign in_exec = state == EXEC_A || state == EXEC_D;
  assign ALE         = state == FETCH_A || state == OPND_A || state == EXEC_A;
  assign En          = state == FETCH_D || state == OPND_D || state == EXEC_D;
  assign Rw          = !(in_exec && is_sta);
  assign Address_Bus = in_exec ? opnd[ADDR_W-1:0] : pc;
  // the bus is released in every state but a store's data phase, so reset frees it at once
  assign Data_Bus    = (state == EXEC_D && is_sta) ? acc : 'z;
  assign sum = {1'b0, acc} + {1'b0, Data_Bus};
  assign dif = {1'b0, acc} - {1'b0, Data_Bus};
  always_comb begin
    res = opc == 4'd4 ? sum[DATA_W-1:0] :
          opc == 4'd5 ? dif[DATA_W-1:0] :
          opc == 4'd6 ? acc & Data_Bus :
          opc == 4'd7 ? acc | Data_Bus : Data_Bus;
    dispReg = regSelect == 2'd0 ? acc :
              regSelect == 2'd1 ? DATA_W'(pc) :
              regSelect == 2'd2 ? ir : {{(DATA_W-2){1'b0}}, c, z};
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH_A;
      pc    <= ADDR_W'(RESET_PC);
      acc   <= '0;
      ir    <= '0;
      opnd  <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
    end else if (!pause) begin
      case (state)
        FETCH_A: state <= FETCH_D;
        FETCH_D: begin
          ir    <= Data_Bus;
          pc    <= pc + 1'b1;
          state <= OPND_A;
        end
        OPND_A: state <= OPND_D;
        OPND_D: begin
          opnd <= Data_Bus;
          pc   <= taken ? Data_Bus[ADDR_W-1:0] : pc + 1'b1;
          if (opc == 4'd1) begin
            acc <= Data_Bus;
            z   <= Data_Bus == '0;
          end
          state <= opc == 4'hF ? HALT : mem_op ? EXEC_A : FETCH_A;
        end
        EXEC_A: state <= EXEC_D;
        EXEC_D: begin
          if (!is_sta) begin
            acc <= res;
            z   <= res == '0;
          end
          // carry is the ninth bit of the sum, or the borrow of the difference
          if (opc == 4'd4 || opc == 4'd5) c <= opc == 4'd4 ? sum[DATA_W] : dif[DATA_W];
          state <= FETCH_A;
        end
        default: state <= state;
      endcase
    end
  end
endmodule
